// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one UART transmitter between CPU stores (buffered in a
// small FIFO) and a debug byte source. A round-robin arbiter picks the next byte
// and a pacing counter keeps uart_wr strobes one byte time apart.
//
// Debug handshake: dbg_valid is raised with dbg_data and held until accepted;
// dbg_ready is high for exactly the cycle in which the byte is taken. A byte is
// transferred on any cycle where dbg_valid && dbg_ready. dbg_ready never rises
// without dbg_valid. It is combinational from dbg_valid, the state and the arbiter.
module uart_tx_sched #(
    parameter int FIFO_DEPTH  = 8,
    parameter int BYTE_CYCLES = 8680
) (
    input  logic                          sysclk,
    input  logic                          cpu_reset,
    input  logic                          cpu_we,
    input  logic [7:0]                    cpu_data,
    output logic                          cpu_full,
    output logic [$clog2(FIFO_DEPTH):0]   cpu_count,
    output logic                          overflow,
    input  logic                          dbg_valid,
    input  logic [7:0]                    dbg_data,
    output logic                          dbg_ready,
    output logic                          uart_wr,
    output logic [7:0]                    uart_dat,
    output logic                          busy
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int CNTW = $clog2(BYTE_CYCLES);
    localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(BYTE_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t          state, state_next;
    logic [CNTW-1:0] pace_cnt;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            last_b;      // 1: previous grant went to the debug port
    logic            req_a, req_b;
    logic            grant_a, grant_b;
    logic            push, pop;

    assign cpu_count = count;
    assign cpu_full  = (count == CNT_FULL);
    // The FSM state is visible on busy: high exactly while in S_WAIT.
    assign busy      = (state == S_WAIT);
    assign dbg_ready = grant_b;

    // Arbitration, FIFO push/pop qualification and next-state selection.
    always_comb begin
        req_a      = (count != '0);
        req_b      = dbg_valid;
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        state_next = state;
        case (state)
            S_IDLE: begin
                if (!cpu_reset) begin
                    if (req_a && req_b) begin
                        grant_a = last_b;
                        grant_b = !last_b;
                    end else begin
                        grant_a = req_a;
                        grant_b = req_b;
                    end
                end
                if (grant_a || grant_b) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (pace_cnt == '0) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        pop  = grant_a;
        // A pop in the same cycle frees the slot the new byte needs.
        push = cpu_we && (!cpu_full || pop);
    end

    // State register, pacing counter, arbiter history and UART strobe.
    always_ff @(posedge sysclk) begin
        if (cpu_reset) begin
            state    <= S_IDLE;
            pace_cnt <= '0;
            last_b   <= 1'b1;
            uart_wr  <= 1'b0;
            uart_dat <= 8'h00;
        end else begin
            state   <= state_next;
            uart_wr <= grant_a || grant_b;
            if (grant_a || grant_b) begin
                pace_cnt <= CNT_LOAD;
                last_b   <= grant_b;
                uart_dat <= grant_a ? mem[rd_ptr] : dbg_data;
            end else if (state == S_WAIT && pace_cnt != '0) begin
                pace_cnt <= pace_cnt - 1'b1;
            end
        end
    end

    // FIFO pointers, occupancy and the sticky drop flag.
    always_ff @(posedge sysclk) begin
        if (cpu_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (cpu_we && !push) overflow <= 1'b1;
        end
    end

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge sysclk) begin
        if (push) mem[wr_ptr] <= cpu_data;
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched with FIFO_DEPTH=4, BYTE_CYCLES=4. Directed vectors push
// hand-computed bytes into exp_q; a monitor pops and compares on every uart_wr.
module tb_uart_tx_sched;

  localparam int DEPTH = 4;
  localparam int BC    = 4;

  logic       sysclk = 1'b0;
  logic       cpu_reset = 1'b1;
  logic       cpu_we = 1'b0;
  logic [7:0] cpu_data = 8'h00;
  logic       cpu_full;
  logic [2:0] cpu_count;
  logic       overflow;
  logic       dbg_valid = 1'b0;
  logic [7:0] dbg_data = 8'h00;
  logic       dbg_ready;
  logic       uart_wr;
  logic [7:0] uart_dat;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int dbg_pulses = 0;
  int t0 = 0;
  int p0 = 0;
  logic [7:0] exp_q[$];
  int st_q[$];

  uart_tx_sched #(.FIFO_DEPTH(DEPTH), .BYTE_CYCLES(BC)) dut (
    .sysclk(sysclk), .cpu_reset(cpu_reset), .cpu_we(cpu_we), .cpu_data(cpu_data),
    .cpu_full(cpu_full), .cpu_count(cpu_count), .overflow(overflow),
    .dbg_valid(dbg_valid), .dbg_data(dbg_data), .dbg_ready(dbg_ready),
    .uart_wr(uart_wr), .uart_dat(uart_dat), .busy(busy)
  );

  // clock / cycle counter
  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic adv();
    @(posedge sysclk);
    #1;
  endtask

  task automatic mid();
    @(negedge sysclk);
  endtask

  task automatic idle(input int n);
    cpu_we = 1'b0;
    dbg_valid = 1'b0;
    repeat (n) adv();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_uart_wr"}, uart_wr, 0);
    check({tag, "_uart_dat"}, uart_dat, 0);
    check({tag, "_cpu_full"}, cpu_full, 0);
    check({tag, "_cpu_count"}, cpu_count, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_dbg_ready"}, dbg_ready, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic do_reset();
    adv();
    cpu_reset = 1'b1;
    cpu_we = 1'b0;
    dbg_valid = 1'b0;
    adv();
    adv();
    cpu_reset = 1'b0;
    mid();
    check_reset_outputs("reset");
  endtask

  task automatic check_strobes(input string name, input int n, input int first, input int gap);
    check({name, "_strobe_count"}, st_q.size(), n);
    for (int i = 0; i < st_q.size() && i < n; i++)
      check({name, "_strobe_time"}, st_q[i] - t0, first + gap * i);
    check({name, "_exp_q_drained"}, exp_q.size(), 0);
  endtask

  // scoreboard monitor
  always @(negedge sysclk) begin
    logic [7:0] e;
    if (uart_wr === 1'b1) begin
      st_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe: got byte 0x%02h expected none (cycle %0d)", uart_dat, cyc);
      end else begin
        e = exp_q.pop_front();
        check("strobe_byte", uart_dat, e);
      end
    end
    if (dbg_ready === 1'b1) begin
      dbg_pulses++;
      check("dbg_ready_without_valid", dbg_valid, 1);
    end
  end

  initial begin
    do_reset();

    // single CPU byte
    st_q.delete();
    exp_q.push_back(8'h41);
    adv(); cpu_we = 1'b1; cpu_data = 8'h41; mid(); t0 = cyc;
    check("single_t0_wr", uart_wr, 0);
    adv(); cpu_we = 1'b0; mid();
    check("single_t1_count", cpu_count, 1);
    check("single_t1_busy", busy, 0);
    adv(); mid();
    check("single_t2_wr", uart_wr, 1);
    check("single_t2_busy", busy, 1);
    check("single_t2_count", cpu_count, 0);
    for (int k = 3; k <= 5; k++) begin
      adv(); mid();
      check("single_wait_busy", busy, 1);
      check("single_wait_wr", uart_wr, 0);
    end
    adv(); mid();
    check("single_t6_busy", busy, 0);
    idle(4);
    check_strobes("single", 1, 2, 5);

    // burst of six CPU bytes; one pop frees a slot, only 0x35 is dropped
    st_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back(8'(8'h30 + i));
    for (int i = 0; i < 8; i++) begin
      adv();
      cpu_we = (i < 6);
      cpu_data = 8'(8'h30 + i);
      mid();
      if (i == 0) t0 = cyc;
      if (i == 2) check("burst_t2_count_we_pop", cpu_count, 1);
      if (i == 4) begin
        check("burst_t4_count", cpu_count, 3);
        check("burst_t4_full", cpu_full, 0);
      end
      if (i == 5) begin
        check("burst_t5_count", cpu_count, 4);
        check("burst_t5_full", cpu_full, 1);
        check("burst_t5_overflow", overflow, 0);
      end
      if (i == 6) begin
        check("burst_t6_overflow", overflow, 1);
        check("burst_t6_count", cpu_count, 4);
      end
      if (i == 7) check("burst_t7_count", cpu_count, 3);
    end
    idle(22);
    check("burst_overflow_sticky", overflow, 1);
    check_strobes("burst", 5, 2, 5);

    // reset clears overflow and restores last=B so A wins the first tie
    do_reset();

    // tie between FIFO and debug port
    st_q.delete();
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h99);
    exp_q.push_back(8'h11);
    p0 = dbg_pulses;
    for (int i = 0; i < 14; i++) begin
      adv();
      cpu_we = (i < 2);
      cpu_data = (i == 0) ? 8'h10 : 8'h11;
      dbg_valid = (i >= 1 && i <= 6);
      dbg_data = 8'h99;
      mid();
      if (i == 0) t0 = cyc;
      if (i == 1) check("tie_t1_dbg_ready", dbg_ready, 0);
      if (i == 6) check("tie_t6_dbg_ready", dbg_ready, 1);
    end
    check("tie_dbg_pulses", dbg_pulses - p0, 1);
    idle(4);
    check_strobes("tie", 3, 2, 5);

    // debug only, second offer made during WAIT
    idle(4);
    st_q.delete();
    exp_q.push_back(8'h7E);
    exp_q.push_back(8'h55);
    p0 = dbg_pulses;
    for (int i = 0; i < 8; i++) begin
      adv();
      dbg_valid = (i <= 5);
      dbg_data = (i == 0) ? 8'h7E : 8'h55;
      mid();
      if (i == 0) begin
        t0 = cyc;
        check("dbg_t0_ready", dbg_ready, 1);
      end
      if (i == 1) check("dbg_t1_wr", uart_wr, 1);
      if (i >= 1 && i <= 4) check("dbg_wait_no_ready", dbg_ready, 0);
      if (i == 5) check("dbg_t5_ready", dbg_ready, 1);
    end
    check("dbg_pulses", dbg_pulses - p0, 2);
    idle(4);
    check_strobes("dbg", 2, 1, 5);

    // full FIFO with a push in the grant cycle
    idle(4);
    st_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(8'(8'hA0 + i));
    for (int i = 0; i < 9; i++) begin
      adv();
      cpu_we = (i <= 4) || (i == 6);
      cpu_data = (i <= 4) ? 8'(8'hA0 + i) : 8'hA5;
      mid();
      if (i == 0) t0 = cyc;
      if (i == 5) begin
        check("fullpop_t5_count", cpu_count, 4);
        check("fullpop_t5_full", cpu_full, 1);
      end
      if (i == 7) begin
        check("fullpop_t7_count", cpu_count, 4);
        check("fullpop_t7_full", cpu_full, 1);
        check("fullpop_t7_overflow", overflow, 0);
      end
    end
    idle(25);
    check("fullpop_overflow_final", overflow, 0);
    check_strobes("fullpop", 6, 2, 5);

    // reset during WAIT with three bytes queued
    idle(4);
    st_q.delete();
    exp_q.push_back(8'hB0);
    for (int i = 0; i < 5; i++) begin
      adv();
      cpu_we = (i <= 3);
      cpu_data = 8'(8'hB0 + i);
      cpu_reset = (i == 4);
      mid();
      if (i == 0) t0 = cyc;
      if (i == 4) begin
        check("rst_mid_count", cpu_count, 3);
        check("rst_mid_busy", busy, 1);
        check("rst_mid_dbg_ready", dbg_ready, 0);
      end
    end
    adv();
    cpu_reset = 1'b0;
    cpu_we = 1'b0;
    mid();
    check_reset_outputs("rst_mid");
    idle(20);
    check_strobes("rst_mid", 1, 2, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
